// File: rtl/hs_arbiter_m.sv
// hs_arbiter_m: round-robin arbiter that lets N four-phase requesters share one
// four-phase resource. The asynchronous req/res_ack inputs are synchronized first.
// A five-state FSM then runs the resource handshake and the client handshake in a
// fixed order. Outputs are registered from the current state, so each output moves
// one edge after the state that drives it.
module hs_arbiter_m #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2,
    localparam int IW         = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  ack,
    output logic          res_req,
    input  logic          res_ack,
    output logic [IW-1:0] grant_idx,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RES_UP = 3'd1,
        ACK_UP = 3'd2,
        RES_DN = 3'd3,
        ACK_DN = 3'd4
    } state_t;

    state_t            state_reg, state_next;
    logic [N-1:0]      req_sync_reg [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] ack_sync_reg;
    logic [N-1:0]      ack_reg, ack_next;
    logic              res_req_reg, res_req_next;
    logic              busy_reg, busy_next;
    logic [IW-1:0]     grant_reg, grant_next;
    logic [IW-1:0]     ptr_reg, ptr_next;
    logic [IW-1:0]     win;
    logic [N-1:0]      sreq;
    logic              sack;

    assign sreq = req_sync_reg[SYNC_STAGES-1];
    assign sack = ack_sync_reg[SYNC_STAGES-1];

    // Multi-flop synchronizers for the client requests and the resource acknowledge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                req_sync_reg[i] <= '0;
            end
            ack_sync_reg <= '0;
        end else begin
            req_sync_reg[0] <= req;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                req_sync_reg[i] <= req_sync_reg[i-1];
            end
            ack_sync_reg <= {ack_sync_reg[SYNC_STAGES-2:0], res_ack};
        end
    end

    // State, grant bookkeeping and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            ack_reg     <= '0;
            res_req_reg <= 1'b0;
            busy_reg    <= 1'b0;
            grant_reg   <= '0;
            ptr_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            ack_reg     <= ack_next;
            res_req_reg <= res_req_next;
            busy_reg    <= busy_next;
            grant_reg   <= grant_next;
            ptr_reg     <= ptr_next;
        end
    end

    // Round-robin pick, next-state logic and next values of the output registers
    always_comb begin
        state_next = state_reg;
        busy_next  = busy_reg;
        grant_next = grant_reg;
        ptr_next   = ptr_reg;
        win        = '0;

        // Scan from the far end down, so the candidate closest to ptr is assigned last.
        for (int i = N - 1; i >= 0; i--) begin
            if (sreq[(int'(ptr_reg) + i) % N]) begin
                win = IW'((int'(ptr_reg) + i) % N);
            end
        end

        case (state_reg)
            IDLE: begin
                if (|sreq) begin
                    grant_next = win;
                    busy_next  = 1'b1;
                    state_next = RES_UP;
                end
            end
            RES_UP: begin
                if (sack) state_next = ACK_UP;
            end
            ACK_UP: begin
                if (!sreq[grant_reg]) state_next = RES_DN;
            end
            RES_DN: begin
                if (!sack) state_next = ACK_DN;
            end
            ACK_DN: begin
                busy_next  = 1'b0;
                ptr_next   = (grant_reg == IW'(N - 1)) ? '0 : grant_reg + IW'(1);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        res_req_next = (state_reg == RES_UP) || (state_reg == ACK_UP);
        ack_next     = '0;
        if ((state_reg == ACK_UP) || (state_reg == RES_DN)) begin
            ack_next[grant_reg] = 1'b1;
        end
    end

    assign ack       = ack_reg;
    assign res_req   = res_req_reg;
    assign busy      = busy_reg;
    assign grant_idx = grant_reg;

endmodule

// File: tb/tb_hs_arbiter_m.sv
// Directed bench for hs_arbiter_m with N=4 and SYNC_STAGES=2. The bench itself plays
// the clients and the shared resource, and prints one line per handshake.
module tb_hs_arbiter_m;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  ack;
    logic          res_req;
    logic          res_ack = 1'b0;
    logic [IW-1:0] grant_idx;
    logic          busy;

    int checks = 0;
    int errors = 0;
    logic onehot_bad = 1'b0;

    hs_arbiter_m #(.N(N), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .req(req), .ack(ack), .res_req(res_req),
        .res_ack(res_ack), .grant_idx(grant_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    // Remember any cycle in which more than one ack bit is set
    always @(negedge clk) begin
        if ($countones(ack) > 1) onehot_bad <= 1'b1;
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait, within a cycle budget, for: 0 res_req==val, 1 ack!=0, 2 busy==val
    task automatic wait_for(input string tag, input int which, input logic val);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            case (which)
                0: hit = (res_req === val);
                1: hit = (ack !== '0);
                default: hit = (busy === val);
            endcase
            if (!hit) tick();
        end
        checks++;
        assert (hit) else begin
            errors++;
            $error("FAIL %s observed=timeout expected=event", tag);
        end
    endtask

    // Act as the resource and as client g for one complete handshake
    task automatic serve(input int g, input bit reraise);
        wait_for("res_req_up", 0, 1'b1);
        res_ack = 1'b1;
        wait_for("ack_up", 1, 1'b1);
        check($sformatf("ack_client%0d", g), 32'(ack), 32'(1 << g));
        check($sformatf("grant_client%0d", g), 32'(grant_idx), 32'(g));
        $display("grant client=%0d ack=%b busy=%b", g, ack, busy);
        req[g] = 1'b0;
        if (reraise) begin
            tick(2);
            req[g] = 1'b1;
        end
        wait_for("res_req_dn", 0, 1'b0);
        res_ack = 1'b0;
        wait_for("busy_dn", 2, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        res_ack = 1'b0;
        tick(2);
        check("rst_ack", 32'(ack), 0);
        check("rst_res_req", 32'(res_req), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_grant", 32'(grant_idx), 0);
        #2 rst = 1'b1;
        tick(2);
    endtask

    initial begin
        bit stuck_ok;

        do_reset();

        // res_ack with nothing pending is ignored
        res_ack = 1'b1;
        tick(6);
        check("idle_ack_busy", 32'(busy), 0);
        check("idle_ack_res_req", 32'(res_req), 0);
        res_ack = 1'b0;
        tick(4);

        // Single client 2 with exact cycle timing
        req = 4'b0100;
        tick(3);
        check("sc_res_req_early", 32'(res_req), 0);
        check("sc_busy_grant", 32'(busy), 1);
        check("sc_grant_idx", 32'(grant_idx), 2);
        tick(1);
        check("sc_res_req_4cyc", 32'(res_req), 1);
        tick(3);
        res_ack = 1'b1;
        tick(3);
        check("sc_ack_not_yet", 32'(ack), 0);
        tick(1);
        check("sc_ack_up", 32'(ack), 4'b0100);
        req = 4'b0000;
        tick(3);
        check("sc_res_req_hold", 32'(res_req), 1);
        tick(1);
        check("sc_res_req_dn", 32'(res_req), 0);
        check("sc_ack_hold", 32'(ack), 4'b0100);
        res_ack = 1'b0;
        tick(3);
        check("sc_busy_hold", 32'(busy), 1);
        tick(1);
        check("sc_ack_dn", 32'(ack), 0);
        check("sc_busy_dn", 32'(busy), 0);
        check("sc_grant_keep", 32'(grant_idx), 2);
        $display("single client 2 handshake done");

        // Fairness after wrap: ptr is now 3
        req = 4'b1001;
        serve(3, 1'b0);
        serve(0, 1'b0);

        // Contention from reset: all request, each re-raises after its ack
        do_reset();
        req = 4'b1111;
        serve(0, 1'b1);
        serve(1, 1'b1);
        serve(2, 1'b1);
        serve(3, 1'b1);
        serve(0, 1'b0);
        req = '0;
        tick(4);

        // Late arrival of client 1 while client 0 is mid-handshake
        do_reset();
        req = 4'b0001;
        wait_for("late_res_req", 0, 1'b1);
        req[1] = 1'b1;
        serve(0, 1'b0);
        tick(1);
        check("late_busy", 32'(busy), 1);
        check("late_grant", 32'(grant_idx), 1);
        serve(1, 1'b0);
        tick(4);

        // Slow resource; client 2 pulses req briefly and must not be granted
        do_reset();
        req = 4'b0001;
        wait_for("slow_res_req", 0, 1'b1);
        stuck_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 2) req[2] = 1'b1;
            if (i == 6) req[2] = 1'b0;
            if (ack !== '0 || busy !== 1'b1) stuck_ok = 1'b0;
            tick();
        end
        check("slow_wait_state", 32'(stuck_ok), 1);
        serve(0, 1'b0);
        tick(6);
        check("dropped_req_ignored", 32'(busy), 0);

        // Asynchronous reset while in ACK_UP
        req = 4'b1000;
        wait_for("ar_res_req", 0, 1'b1);
        res_ack = 1'b1;
        wait_for("ar_ack", 1, 1'b1);
        check("ar_ack_up", 32'(ack), 4'b1000);
        req[1] = 1'b1;
        tick(1);
        #3 rst = 1'b0;
        #1;
        check("ar_ack_async", 32'(ack), 0);
        check("ar_res_req_async", 32'(res_req), 0);
        check("ar_busy_async", 32'(busy), 0);
        res_ack = 1'b0;
        #2 rst = 1'b1;
        wait_for("ar_regrant", 2, 1'b1);
        check("ar_first_grant", 32'(grant_idx), 1);
        serve(1, 1'b0);
        serve(3, 1'b0);
        tick(4);

        check("ack_onehot0", 32'(onehot_bad), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
